// File: rtl/sdram_pkg.sv
// Shared command encodings, FSM states, error causes and mode-word rules for the SDRAM init monitor.
// mode_word_ok is only consulted when SDRAM_MODE_CHECK_EN is defined.
package sdram_pkg;

  typedef enum logic [2:0] {
    CMD_NOP   = 3'd0,
    CMD_PRE   = 3'd1,
    CMD_REF   = 3'd2,
    CMD_MRS   = 3'd3,
    CMD_OTHER = 3'd4
  } cmd_t;

  typedef enum logic [2:0] {
    S_PWR = 3'd0,
    S_REF = 3'd1,
    S_MRD = 3'd2,
    S_RDY = 3'd3,
    S_ERR = 3'd4
  } state_t;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_EARLY   = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
  localparam logic [2:0] ERR_FEW_REF = 3'd3;
  localparam logic [2:0] ERR_TIMING  = 3'd4;
  localparam logic [2:0] ERR_MODE    = 3'd5;
  localparam logic [2:0] ERR_MRD     = 3'd6;

  // A deselected chip is indistinguishable from a NOP as far as the protocol is concerned.
  function automatic cmd_t decode_cmd(input logic cs_n, input logic ras_n,
                                      input logic cas_n, input logic we_n);
    cmd_t cmd;
    if (cs_n) begin
      cmd = CMD_NOP;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b111:  cmd = CMD_NOP;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        default: cmd = CMD_OTHER;
      endcase
    end
    return cmd;
  endfunction

  // Reserved bits clear, CAS latency 2 or 3, sequential burst of 1/2/4/8.
  function automatic logic mode_word_ok(input logic [12:0] addr);
    return (addr[12:10] == 3'b000) &&
           ((addr[6:4] == 3'b010) || (addr[6:4] == 3'b011)) &&
           (addr[3] == 1'b0) && (addr[2] == 1'b0);
  endfunction

endpackage

// File: rtl/sdram_gap_timer.sv
// Saturating count of enabled cycles since the last non-NOP command, with minimum-spacing flags.
// The flags count the current cycle, so a command one cycle after its predecessor sees an elapsed time of 1.
module sdram_gap_timer #(
  parameter int unsigned TRP_CYCLES  = 1,
  parameter int unsigned TRFC_CYCLES = 2,
  parameter int unsigned TMRD_CYCLES = 2
) (
  input  logic iclk,
  input  logic ctr_reset,
  input  logic enable,
  input  logic restart,
  output logic trp_ok,
  output logic trfc_ok,
  output logic tmrd_ok
);

  localparam logic [8:0] TRP_LIM  = 9'(TRP_CYCLES);
  localparam logic [8:0] TRFC_LIM = 9'(TRFC_CYCLES);
  localparam logic [8:0] TMRD_LIM = 9'(TMRD_CYCLES);

  logic [7:0] count;
  logic [8:0] elapsed;

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      count <= '0;
    end else if (enable) begin
      if (restart) begin
        count <= '0;
      end else if (count != 8'hFF) begin
        count <= count + 8'd1;
      end
    end
  end

  assign elapsed = {1'b0, count} + 9'd1;
  assign trp_ok  = (elapsed >= TRP_LIM);
  assign trfc_ok = (elapsed >= TRFC_LIM);
  assign tmrd_ok = (elapsed >= TMRD_LIM);

endmodule

// File: rtl/sdram_init_monitor.sv
// Watches the SDRAM command bus through power-up, PRECHARGE ALL, AUTO REFRESH and MRS, reporting ready or a sticky error.
// Define SDRAM_MODE_CHECK_EN to also reject MRS words with unsupported CAS latency / burst settings.
module sdram_init_monitor
  import sdram_pkg::*;
#(
  parameter int unsigned POWERUP_CYCLES = 10000,
  parameter int unsigned MIN_REFRESH    = 2,
  parameter int unsigned TRP_CYCLES     = 1,
  parameter int unsigned TRFC_CYCLES    = 2,
  parameter int unsigned TMRD_CYCLES    = 2
) (
  input  logic        iclk,
  input  logic        ctr_reset,
  input  logic        ienb,
  input  logic        DRAM_CKE,
  input  logic        DRAM_CS_N,
  input  logic        DRAM_RAS_N,
  input  logic        DRAM_CAS_N,
  input  logic        DRAM_WE_N,
  input  logic [1:0]  DRAM_BA,
  input  logic [12:0] DRAM_ADDR,
  output logic        oready,
  output logic        oerr,
  output logic [2:0]  oerr_code,
  output logic [12:0] omode_reg,
  output logic [7:0]  oref_count,
  output logic [2:0]  ostate
);

  localparam int unsigned PW = $clog2(POWERUP_CYCLES + 1);
  localparam logic [PW-1:0] PWR_MIN = PW'(POWERUP_CYCLES);
  localparam logic [7:0]    REF_MIN = 8'(MIN_REFRESH);

  state_t state, state_next;
  cmd_t cmd;
  logic [PW-1:0] pwr_cnt;
  logic [7:0] ref_count;
  logic [12:0] mode_reg;
  logic [2:0] err_code, err_next;
  logic last_ref;
  logic trp_ok, trfc_ok, tmrd_ok, gap_ok, mode_ok;
  logic restart, ref_inc, mode_cap;
  logic bus_unused;

  assign cmd        = decode_cmd(DRAM_CS_N, DRAM_RAS_N, DRAM_CAS_N, DRAM_WE_N);
  assign restart    = ienb && (cmd != CMD_NOP);
  assign gap_ok     = last_ref ? trfc_ok : trp_ok;
  assign bus_unused = ^DRAM_BA;

`ifdef SDRAM_MODE_CHECK_EN
  assign mode_ok = mode_word_ok(DRAM_ADDR);
`else
  assign mode_ok = 1'b1;
`endif

  sdram_gap_timer #(
    .TRP_CYCLES (TRP_CYCLES),
    .TRFC_CYCLES(TRFC_CYCLES),
    .TMRD_CYCLES(TMRD_CYCLES)
  ) u_gap (
    .iclk     (iclk),
    .ctr_reset(ctr_reset),
    .enable   (ienb),
    .restart  (restart),
    .trp_ok   (trp_ok),
    .trfc_ok  (trfc_ok),
    .tmrd_ok  (tmrd_ok)
  );

  // Violations are resolved before any counter strobe so an offending command never also counts.
  always_comb begin
    state_next = state;
    err_next   = ERR_NONE;
    ref_inc    = 1'b0;
    mode_cap   = 1'b0;
    if (ienb) begin
      case (state)
        S_PWR: begin
          if (cmd != CMD_NOP) begin
            if (pwr_cnt < PWR_MIN)                   err_next   = ERR_EARLY;
            else if (cmd == CMD_PRE && DRAM_ADDR[10]) state_next = S_REF;
            else                                     err_next   = ERR_ORDER;
          end
        end
        S_REF: begin
          case (cmd)
            CMD_REF: begin
              if (!gap_ok) err_next = ERR_TIMING;
              else         ref_inc  = 1'b1;
            end
            CMD_MRS: begin
              if (ref_count < REF_MIN) err_next = ERR_FEW_REF;
              else if (!gap_ok)        err_next = ERR_TIMING;
              else if (!mode_ok)       err_next = ERR_MODE;
              else begin
                mode_cap   = 1'b1;
                state_next = S_MRD;
              end
            end
            CMD_PRE, CMD_NOP: ;
            default: err_next = ERR_ORDER;
          endcase
        end
        S_MRD: begin
          if (cmd != CMD_NOP) err_next   = ERR_MRD;
          else if (tmrd_ok)   state_next = S_RDY;
        end
        S_RDY: begin
          if (cmd == CMD_MRS && mode_ok) mode_cap = 1'b1;
        end
        default: ;
      endcase
    end
    if (err_next != ERR_NONE) state_next = S_ERR;
  end

  always_ff @(posedge iclk or posedge ctr_reset) begin
    if (ctr_reset) begin
      state     <= S_PWR;
      pwr_cnt   <= '0;
      ref_count <= '0;
      mode_reg  <= '0;
      err_code  <= ERR_NONE;
      last_ref  <= 1'b0;
    end else begin
      state <= state_next;
      if (err_next != ERR_NONE) err_code <= err_next;
      if (ienb && state == S_PWR) begin
        if (!DRAM_CKE)                             pwr_cnt <= '0;
        else if (cmd == CMD_NOP && pwr_cnt != '1) pwr_cnt <= pwr_cnt + 1'b1;
      end
      if (ref_inc && ref_count != 8'hFF) ref_count <= ref_count + 8'd1;
      if (mode_cap)                      mode_reg  <= DRAM_ADDR;
      if (restart)                       last_ref  <= (cmd == CMD_REF);
    end
  end

  assign oready     = (state == S_RDY);
  assign oerr       = (state == S_ERR);
  assign oerr_code  = err_code;
  assign omode_reg  = mode_reg;
  assign oref_count = ref_count;
  assign ostate     = state;

endmodule
